// File: rtl/sha256_stream_core.sv
// Streaming SHA-256 / SHA-224 engine: big-endian word stream in, FIPS 180-4 padding done
// internally, ROUNDS_PER_CYCLE compression rounds per clock, digest held on valid/ready.
module sha256_stream_core #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         mode_224,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [2:0]   in_bytes,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] digest
);
  localparam int R = ROUNDS_PER_CYCLE;

  if (R != 1 && R != 2 && R != 4 && R != 8) begin : g_bad_rounds
    $error("sha256_stream_core: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] IV_256 [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                         32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] IV_224 [8] = '{32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                                         32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PAD, S_HASH, S_UPDATE, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] h_q [8];
  logic [31:0] wv_q [8];
  logic [31:0] w_q [16];
  logic [31:0] wv_nxt [8];
  logic [31:0] w_nxt [16];
  logic [31:0] t1, t2, ws, load_word;
  logic [4:0]  idx_q;
  logic [5:0]  rnd_q;
  logic [63:0] bit_cnt_q;
  logic [2:0]  nb;
  logic        pad1_q, len_q, last_q, m224_q, accept, len_fits;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  assign in_ready  = (state == S_LOAD);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_DONE);
  assign accept    = in_ready & in_valid;
  // Length fits if words 14/15 are still free once the 0x80 byte has a home.
  assign len_fits  = pad1_q ? (idx_q <= 5'd14) : (idx_q <= 5'd13);

  always_comb begin
    digest = '0;
    if (state == S_DONE)
      digest = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4], h_q[5], h_q[6], m224_q ? 32'h0 : h_q[7]};
  end

  // Tail word: keep the first nb bytes, put 0x80 right after them, zero the rest.
  always_comb begin
    nb        = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
    load_word = in_data;
    if (in_last && nb != 3'd4)
      load_word = (in_data & ~(32'hFFFF_FFFF >> {nb, 3'b000})) | (32'h8000_0000 >> {nb, 3'b000});
  end

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    wv_nxt = wv_q;
    w_nxt  = w_q;
    t1     = '0;
    t2     = '0;
    ws     = '0;
    for (int r = 0; r < R; r++) begin
      t1 = wv_nxt[7] + big_sigma1(wv_nxt[4]) + ((wv_nxt[4] & wv_nxt[5]) ^ (~wv_nxt[4] & wv_nxt[6]))
         + K[rnd_q + 6'(r)] + w_nxt[0];
      t2 = big_sigma0(wv_nxt[0]) + ((wv_nxt[0] & wv_nxt[1]) ^ (wv_nxt[0] & wv_nxt[2]) ^ (wv_nxt[1] & wv_nxt[2]));
      ws = small_sigma1(w_nxt[14]) + w_nxt[9] + small_sigma0(w_nxt[1]) + w_nxt[0];
      for (int i = 7; i > 0; i--) wv_nxt[i] = wv_nxt[i-1];
      wv_nxt[4] = wv_nxt[4] + t1;
      wv_nxt[0] = t1 + t2;
      for (int i = 0; i < 15; i++) w_nxt[i] = w_nxt[i+1];
      w_nxt[15] = ws;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_LOAD;
      S_LOAD:   if (accept) begin
                  if (idx_q == 5'd15)  state_nxt = S_HASH;
                  else if (in_last)    state_nxt = S_PAD;
                end
      S_PAD:    state_nxt = S_HASH;
      S_HASH:   if (rnd_q == 6'(64 - R)) state_nxt = S_UPDATE;
      S_UPDATE: if (last_q && !len_q) state_nxt = S_PAD;
                else if (last_q)      state_nxt = S_DONE;
                else                  state_nxt = S_LOAD;
      S_DONE:   if (out_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      idx_q     <= '0;
      rnd_q     <= '0;
      bit_cnt_q <= '0;
      pad1_q    <= 1'b0;
      len_q     <= 1'b0;
      last_q    <= 1'b0;
      m224_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_nxt;
      case (state)
        S_IDLE: if (start) begin
          m224_q    <= mode_224;
          idx_q     <= '0;
          bit_cnt_q <= '0;
          pad1_q    <= 1'b0;
          len_q     <= 1'b0;
          last_q    <= 1'b0;
        end
        S_LOAD: if (accept) begin
          idx_q     <= idx_q + 5'd1;
          bit_cnt_q <= bit_cnt_q + (in_last ? 64'({nb, 3'b000}) : 64'd32);
          rnd_q     <= '0;
          if (in_last) begin
            last_q <= 1'b1;
            if (nb != 3'd4) pad1_q <= 1'b1;
          end
        end
        S_PAD: begin
          pad1_q <= 1'b1;
          rnd_q  <= '0;
          if (len_fits) len_q <= 1'b1;
        end
        S_HASH:   rnd_q <= rnd_q + 6'(R);
        S_UPDATE: idx_q <= '0;
        default: ;
      endcase
    end
  end

  // NOTE: hash state and schedule carry no reset; each is written before it is read.
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: if (start)
        for (int i = 0; i < 8; i++) h_q[i] <= mode_224 ? IV_224[i] : IV_256[i];
      S_LOAD: if (accept) begin
        w_q[idx_q[3:0]] <= load_word;
        if (idx_q == 5'd15) wv_q <= h_q;
      end
      S_PAD: begin
        for (int i = 0; i < 16; i++)
          if (5'(i) >= idx_q) w_q[i] <= (5'(i) == idx_q && !pad1_q) ? 32'h8000_0000 : 32'h0;
        if (len_fits) begin
          w_q[14] <= bit_cnt_q[63:32];
          w_q[15] <= bit_cnt_q[31:0];
        end
        wv_q <= h_q;
      end
      S_HASH: begin
        wv_q <= wv_nxt;
        w_q  <= w_nxt;
      end
      S_UPDATE: for (int i = 0; i < 8; i++) h_q[i] <= h_q[i] + wv_q[i];
      default: ;
    endcase
  end
endmodule

// File: tb/tb_sha256_stream_core.sv
// Self-checking bench for sha256_stream_core: known vectors, random lengths against a
// byte-level software SHA-256 model, handshake backpressure and mid-hash reset.
module tb_sha256_stream_core;
  localparam int RPC  = 4;
  localparam int NCYC = 64 / RPC;

  typedef logic [7:0] byte_q_t [$];

  localparam logic [255:0] ABC_256   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] EMPTY_256 = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] ABC_224   = 256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
  localparam logic [255:0] LONG_256  = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk = 1'b0, reset_n = 1'b0, start = 1'b0, mode_224 = 1'b0;
  logic         in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [31:0]  in_data = '0;
  logic [2:0]   in_bytes = '0;
  logic         in_ready, busy, out_valid;
  logic [255:0] digest;
  int           errors = 0, checks = 0, cyc = 0;

  sha256_stream_core #(.ROUNDS_PER_CYCLE(RPC)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode_224(mode_224),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .in_bytes(in_bytes), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .digest(digest)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit (errors=%0d)", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- software reference model ----------------
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] ref_hash(input byte_q_t m, input bit m224);
    byte_q_t     p;
    logic [31:0] hv [8];
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    logic [63:0] bits;
    p    = m;
    bits = 64'(m.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    if (m224) hv = '{32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                     32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
    else      hv = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                     32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    for (int blk = 0; blk < p.size() / 64; blk++) begin
      for (int t = 0; t < 16; t++)
        w[t] = {p[64*blk+4*t], p[64*blk+4*t+1], p[64*blk+4*t+2], p[64*blk+4*t+3]};
      for (int t = 16; t < 64; t++)
        w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
             + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3]; e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
      for (int t = 0; t < 64; t++) begin
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      hv[0] += a; hv[1] += b; hv[2] += c; hv[3] += d;
      hv[4] += e; hv[5] += f; hv[6] += g; hv[7] += h;
    end
    return {hv[0], hv[1], hv[2], hv[3], hv[4], hv[5], hv[6], m224 ? 32'h0 : hv[7]};
  endfunction

  function automatic byte_q_t str2q(input string s);
    byte_q_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic byte_q_t rand_msg(input int len);
    byte_q_t q;
    for (int i = 0; i < len; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  // ---------------- stimulus / capture ----------------
  task automatic run_msg(input byte_q_t m, input bit m224, input int gap_max,
                         input bit pulse_start, output int e_cyc);
    int          nw;
    bit          acc;
    logic [31:0] wd;
    nw = (m.size() == 0) ? 1 : (m.size() + 3) / 4;
    start = 1'b1; mode_224 = m224;
    @(posedge clk); #1;
    start = 1'b0; mode_224 = 1'($urandom);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_ack busy=%b in_ready=%b expected 1/1", busy, in_ready);
    end
    @(posedge clk); #1;
    for (int i = 0; i < nw; i++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(gap_max, 0)) begin @(posedge clk); #1; end
      wd = $urandom;
      for (int b = 0; b < 4; b++)
        if (4*i + b < m.size()) wd[31-8*b -: 8] = m[4*i+b];
      in_data  = wd;
      in_last  = (i == nw - 1);
      in_bytes = in_last ? 3'(m.size() - 4*i) : 3'($urandom);
      in_valid = 1'b1;
      if (pulse_start) begin start = 1'($urandom); mode_224 = 1'($urandom); end
      acc = 1'b0;
      for (int k = 0; k < 300 && !acc; k++) begin
        @(negedge clk); acc = in_ready;
        @(posedge clk); #1;
      end
      if (!acc) begin
        checks++; errors++;
        $display("FAIL in_ready_timeout word=%0d in_ready=%b expected 1", i, in_ready);
      end
    end
    e_cyc    = cyc;
    in_valid = 1'b0;
    in_last  = 1'b0;
    start    = 1'b0;
  endtask

  task automatic get_digest(input int hold, output logic [255:0] dig, output int t_seen);
    bit seen = 1'b0;
    bit stable = 1'b1;
    for (int k = 0; k < 1000 && !seen; k++) begin
      @(negedge clk);
      seen = out_valid;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL out_valid_timeout out_valid=%b expected 1", out_valid); end
    dig    = digest;
    t_seen = cyc;
    repeat (hold) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || digest !== dig) stable = 1'b0;
    end
    if (hold > 0) begin
      checks++;
      if (!stable) begin errors++; $display("FAIL hold_stable out_valid=%b digest=%h expected %h", out_valid, digest, dig); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_handshake out_valid=%b busy=%b expected 0/0", out_valid, busy);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (digest !== '0) begin errors++; $display("FAIL reset_digest got=%h exp=0", digest); end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_known_vectors();
    logic [255:0] dig;
    int e, t;
    run_msg(str2q("abc"), 1'b0, 0, 1'b0, e);
    get_digest(0, dig, t);
    checks++; if (dig !== ABC_256) begin errors++; $display("FAIL abc256 got=%h exp=%h", dig, ABC_256); end
    checks++; if (t - e !== NCYC + 2) begin errors++; $display("FAIL abc_latency got=%0d exp=%0d", t - e, NCYC + 2); end

    run_msg(str2q(""), 1'b0, 0, 1'b0, e);
    get_digest(0, dig, t);
    checks++; if (dig !== EMPTY_256) begin errors++; $display("FAIL empty256 got=%h exp=%h", dig, EMPTY_256); end

    run_msg(str2q("abc"), 1'b1, 0, 1'b0, e);
    get_digest(0, dig, t);
    checks++; if (dig !== ABC_224) begin errors++; $display("FAIL abc224 got=%h exp=%h", dig, ABC_224); end

    run_msg(str2q("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq"), 1'b0, 0, 1'b0, e);
    get_digest(0, dig, t);
    checks++; if (dig !== LONG_256) begin errors++; $display("FAIL long56 got=%h exp=%h", dig, LONG_256); end
    checks++; if (t - e !== 2*NCYC + 4) begin errors++; $display("FAIL long56_latency got=%0d exp=%0d", t - e, 2*NCYC + 4); end
  endtask

  task automatic test_random_lengths();
    int lens [12] = '{64, 55, 56, 63, 119, 120, 128, 0, 0, 0, 0, 0};
    byte_q_t m;
    logic [255:0] dig, exp;
    bit m224;
    int e, t;
    for (int i = 7; i < 12; i++) lens[i] = $urandom_range(200, 1);
    for (int i = 0; i < 12; i++) begin
      m    = rand_msg(lens[i]);
      m224 = (i == 0) ? 1'b0 : 1'($urandom);
      exp  = ref_hash(m, m224);
      run_msg(m, m224, 0, 1'b0, e);
      get_digest(0, dig, t);
      checks++;
      if (dig !== exp) begin errors++; $display("FAIL random len=%0d m224=%b got=%h exp=%h", lens[i], m224, dig, exp); end
    end
  endtask

  task automatic test_backpressure();
    byte_q_t m;
    logic [255:0] dig, exp;
    int e, t;
    m   = rand_msg(97);
    exp = ref_hash(m, 1'b0);
    run_msg(m, 1'b0, 0, 1'b0, e);
    get_digest(0, dig, t);
    checks++; if (dig !== exp) begin errors++; $display("FAIL nogap got=%h exp=%h", dig, exp); end
    run_msg(m, 1'b0, 4, 1'b0, e);
    get_digest(20, dig, t);
    checks++; if (dig !== exp) begin errors++; $display("FAIL gaps_hold got=%h exp=%h", dig, exp); end
    m   = rand_msg(70);
    exp = ref_hash(m, 1'b1);
    run_msg(m, 1'b1, 2, 1'b1, e);
    get_digest(0, dig, t);
    checks++; if (dig !== exp) begin errors++; $display("FAIL start_pulses got=%h exp=%h", dig, exp); end
  endtask

  task automatic test_out_ready_early();
    bit seen = 1'b0;
    int e;
    out_ready = 1'b1;
    run_msg(str2q("abc"), 1'b0, 0, 1'b0, e);
    for (int k = 0; k < 1000 && !seen; k++) begin
      @(negedge clk);
      seen = out_valid;
    end
    checks++;
    if (!seen || digest !== ABC_256) begin
      errors++; $display("FAIL early_ready_digest seen=%b got=%h exp=%h", seen, digest, ABC_256);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL early_ready_drop out_valid=%b busy=%b expected 0/0", out_valid, busy);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_hash();
    logic [255:0] dig;
    int e, t;
    run_msg(str2q("abc"), 1'b0, 0, 1'b0, e);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || digest !== '0) begin
      errors++;
      $display("FAIL mid_reset in_ready=%b busy=%b out_valid=%b digest=%h expected all 0",
               in_ready, busy, out_valid, digest);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_msg(str2q("abc"), 1'b0, 1, 1'b0, e);
    get_digest(0, dig, t);
    checks++; if (dig !== ABC_256) begin errors++; $display("FAIL after_reset_abc got=%h exp=%h", dig, ABC_256); end
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_random_lengths();
    test_backpressure();
    test_out_ready_early();
    test_reset_mid_hash();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
